// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern-scan controller.
package seq_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned FILL_W = 4;   // holds 0..WORD_W
  localparam int unsigned BCNT_W = 3;   // counts shifts 0..WORD_W-1

  localparam logic [WORD_W-1:0] PAT_RST = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/seq_window8.sv
// 8-bit sliding match window with fill tracking and a registered match pulse.
//   clk, rst_n : clock, async active-low reset
//   clr        : empty the window (fill -> 0); ignored bits are masked by fill
//   shift      : shift bit_in into the window LSB this edge
//   bit_in     : serial data bit
//   pat        : pattern to compare against (bit 7 oldest)
//   hit_c      : match condition for the current edge (feeds the hit counter)
//   hit        : registered one-cycle match pulse
module seq_window8
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift,
  input  logic              bit_in,
  input  logic [WORD_W-1:0] pat,
  output logic              hit_c,
  output logic              hit
);

  logic [WORD_W-1:0] win_q, win_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              hit_q, hit_d;

  // Next window/fill; a hit needs a fully populated window equal to pat.
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    hit_d  = 1'b0;
    if (clr) begin
      fill_d = '0;
    end else if (shift) begin
      win_d = {win_q[WORD_W-2:0], bit_in};
      if (fill_q != FILL_W'(WORD_W)) fill_d = fill_q + FILL_W'(1);
      hit_d = (fill_d == FILL_W'(WORD_W)) && (win_d == pat);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
      hit_q  <= hit_d;
    end
  end

  assign hit_c = hit_d;
  assign hit   = hit_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-serial scan controller: accepts 8-bit words, shifts them MSB-first
// into a pattern window, counts matches and gates pattern reprogramming to IDLE.
//   clk, clrn          : clock, async active-low reset
//   cfg_we, cfg_pat    : pattern write (IDLE only, wins over in_valid)
//   cont               : 1 = window spans words, 0 = window flushed per word
//   cnt_clr            : synchronous clear of hit_cnt (wins over a hit)
//   in_valid, in_data  : word source handshake
//   in_ready           : combinational accept qualifier
//   hit, hit_cnt       : match pulse and saturating match count
//   busy, pat          : SHIFT state flag and current pattern
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              cfg_we,
  input  logic [WORD_W-1:0] cfg_pat,
  input  logic              cont,
  input  logic              cnt_clr,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              busy,
  output logic [WORD_W-1:0] pat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WORD_W-1:0] pat_q, pat_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              shift, win_clr, hit_c;

  // FSM next state, word shift register, pattern load and window control.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    pat_d    = pat_q;
    bcnt_d   = bcnt_q;
    in_ready = 1'b0;
    shift    = 1'b0;
    win_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !cfg_we;
        if (cfg_we) begin
          pat_d   = cfg_pat;
          win_clr = 1'b1;
        end else if (in_valid) begin
          sreg_d  = in_data;
          bcnt_d  = '0;
          win_clr = !cont;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift  = 1'b1;
        sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
        bcnt_d = bcnt_q + BCNT_W'(1);
        if (bcnt_q == BCNT_W'(WORD_W - 1)) state_d = IDLE;
      end
    endcase
  end

  // Saturating hit counter; clear wins over a coincident hit.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      pat_q   <= PAT_RST;
      bcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      pat_q   <= pat_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  seq_window8 u_window (
    .clk    (clk),
    .rst_n  (clrn),
    .clr    (win_clr),
    .shift  (shift),
    .bit_in (sreg_q[WORD_W-1]),
    .pat    (pat_q),
    .hit_c  (hit_c),
    .hit    (hit)
  );

  assign hit_cnt = cnt_q;
  assign busy    = (state_q == SHIFT);
  assign pat     = pat_q;

endmodule
